// File: rtl/dadda_pkg.sv
// dadda_pkg -- shared constants and helpers for the pipelined Dadda multiplier.
//   PIPE_STAGES  : register stages between operand acceptance and product output
//   prod_width   : product width derived from operand width
//   dadda_height : Dadda target-height sequence 2,3,4,6,9,13,19,28,...
//   dadda_levels : number of reduction levels needed for a given column height
package dadda_pkg;

  localparam int PIPE_STAGES = 3;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  // d(0)=2, d(j+1)=floor(1.5*d(j))
  function automatic int dadda_height(input int j);
    int d;
    d = 2;
    for (int k = 0; k < j; k++) begin
      d = (d * 3) / 2;
    end
    return d;
  endfunction

  // Count of sequence entries strictly below the tallest column height;
  // each one is a reduction level.
  function automatic int dadda_levels(input int h);
    int n;
    n = 0;
    while (dadda_height(n) < h) begin
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/dadda_tree.sv
// dadda_tree -- combinational partial-product generation and Dadda reduction
// down to two rows of width 2*WIDTH.
//   a, b        : operands
//   signed_mode : 1 = Baugh-Wooley two's-complement partial products
//   row0, row1  : the two remaining rows; row0 + row1 (mod 2^(2*WIDTH)) = a*b
module dadda_tree
  import dadda_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int PW    = prod_width(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic [PW-1:0]    row0,
  output logic [PW-1:0]    row1
);

  localparam int MAXH = WIDTH + 1;
  localparam int NLEV = dadda_levels(WIDTH);

  // Flattened partial-product matrix: bit gi*WIDTH+gj = a[gj]&b[gi], weight gi+gj.
  // In signed mode the terms pairing exactly one MSB with a non-MSB are inverted.
  logic [WIDTH*WIDTH-1:0] w_pp;

  genvar gi, gj;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_row
      for (gj = 0; gj < WIDTH; gj++) begin : g_col
        if ((gi == WIDTH-1) != (gj == WIDTH-1)) begin : g_inv
          assign w_pp[gi*WIDTH+gj] = signed_mode ^ (a[gj] & b[gi]);
        end else begin : g_pos
          assign w_pp[gi*WIDTH+gj] = a[gj] & b[gi];
        end
      end
    end
  endgenerate

  // Columns are kept as packed bit stacks: push shifts a bit in at bit 0,
  // pop takes bit 0 and shifts down, so the live bits are always the low hc[c].
  always_comb begin
    logic [MAXH-1:0] cur [PW];
    logic [MAXH-1:0] nxt [PW];
    int              hc  [PW];
    int              hn  [PW];
    int              d;
    int              ex;
    logic            x, y, z;

    d    = 2;
    ex   = 0;
    x    = 1'b0;
    y    = 1'b0;
    z    = 1'b0;
    row0 = '0;
    row1 = '0;
    for (int c = 0; c < PW; c++) begin
      cur[c] = '0;
      nxt[c] = '0;
      hc[c]  = 0;
      hn[c]  = 0;
    end

    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        cur[i+j] = {cur[i+j][MAXH-2:0], w_pp[i*WIDTH+j]};
        hc[i+j]  = hc[i+j] + 1;
      end
    end

    // Baugh-Wooley correction constants at weights WIDTH and 2*WIDTH-1
    cur[WIDTH] = {cur[WIDTH][MAXH-2:0], signed_mode};
    hc[WIDTH]  = hc[WIDTH] + 1;
    cur[PW-1]  = {cur[PW-1][MAXH-2:0], signed_mode};
    hc[PW-1]   = hc[PW-1] + 1;

    for (int lv = NLEV - 1; lv >= 0; lv--) begin
      d = dadda_height(lv);
      for (int c = 0; c < PW; c++) begin
        nxt[c] = '0;
        hn[c]  = 0;
      end
      for (int c = 0; c < PW; c++) begin
        // hn[c] already counts carries arriving from column c-1 this level
        ex = hc[c] + hn[c] - d;
        for (int f = 0; f < MAXH; f++) begin
          if (ex >= 2 && hc[c] >= 3) begin
            x      = cur[c][0];
            y      = cur[c][1];
            z      = cur[c][2];
            cur[c] = cur[c] >> 3;
            hc[c]  = hc[c] - 3;
            nxt[c] = {nxt[c][MAXH-2:0], x ^ y ^ z};
            hn[c]  = hn[c] + 1;
            if (c + 1 < PW) begin
              nxt[c+1] = {nxt[c+1][MAXH-2:0], (x & y) | (x & z) | (y & z)};
              hn[c+1]  = hn[c+1] + 1;
            end
            ex = ex - 2;
          end else if (ex >= 1 && hc[c] >= 2) begin
            x      = cur[c][0];
            y      = cur[c][1];
            cur[c] = cur[c] >> 2;
            hc[c]  = hc[c] - 2;
            nxt[c] = {nxt[c][MAXH-2:0], x ^ y};
            hn[c]  = hn[c] + 1;
            if (c + 1 < PW) begin
              nxt[c+1] = {nxt[c+1][MAXH-2:0], x & y};
              hn[c+1]  = hn[c+1] + 1;
            end
            ex = ex - 1;
          end
        end
        // untouched bits pass straight through to the next level
        for (int r = 0; r < MAXH; r++) begin
          if (hc[c] > 0) begin
            nxt[c] = {nxt[c][MAXH-2:0], cur[c][0]};
            cur[c] = cur[c] >> 1;
            hc[c]  = hc[c] - 1;
            hn[c]  = hn[c] + 1;
          end
        end
      end
      for (int c = 0; c < PW; c++) begin
        cur[c] = nxt[c];
        hc[c]  = hn[c];
      end
    end

    for (int c = 0; c < PW; c++) begin
      row0[c] = (hc[c] >= 1) ? cur[c][0] : 1'b0;
      row1[c] = (hc[c] >= 2) ? cur[c][1] : 1'b0;
    end
  end

endmodule

// File: rtl/dadda_mult_pipe.sv
// dadda_mult_pipe -- 3-stage pipelined Dadda multiplier with valid/ready flow.
//   S1 registers operands+mode, S2 registers the two Dadda rows, S3 registers
//   the final sum. Each stage advances when empty or when its successor advances.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake; in_a, in_b operands, in_signed mode
//   out_valid/out_ready  : product handshake; out_p = in_a*in_b mod 2^PROD_W
// Configuration macro DADDA_MULT_SIGNED_EN: when defined, in_signed=1 selects
// a two's-complement product; otherwise in_signed is ignored (unsigned only).
module dadda_mult_pipe
  import dadda_pkg::*;
#(
  parameter  int WIDTH  = 8,
  localparam int PROD_W = prod_width(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_p
);

  logic              r_v1, r_v2, r_v3;
  logic [WIDTH-1:0]  r_a, r_b;
  logic              r_sgn;
  logic [PROD_W-1:0] r_row0, r_row1;
  logic [PROD_W-1:0] r_p;

  logic              w_adv1, w_adv2, w_adv3;
  logic              w_mode;
  logic [PROD_W-1:0] w_row0, w_row1;

`ifdef DADDA_MULT_SIGNED_EN
  assign w_mode = in_signed;
`else
  logic w_unused_signed;
  assign w_unused_signed = in_signed;
  assign w_mode          = 1'b0;
`endif

  // Bubble-collapsing advance chain, evaluated from the output backwards
  assign w_adv3    = !r_v3 || out_ready;
  assign w_adv2    = !r_v2 || w_adv3;
  assign w_adv1    = !r_v1 || w_adv2;
  assign in_ready  = w_adv1;
  assign out_valid = r_v3;
  assign out_p     = r_p;

  dadda_tree #(.WIDTH(WIDTH)) u_tree (
    .a           (r_a),
    .b           (r_b),
    .signed_mode (r_sgn),
    .row0        (w_row0),
    .row1        (w_row1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_sgn <= 1'b0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_a   <= in_a;
        r_b   <= in_b;
        r_sgn <= w_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_row0 <= '0;
      r_row1 <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_row0 <= w_row0;
        r_row1 <= w_row1;
      end
    end
  end

  // Final carry-propagate add; the carry out of bit PROD_W-1 is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3 <= 1'b0;
      r_p  <= '0;
    end else if (w_adv3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_p <= r_row0 + r_row1;
      end
    end
  end

endmodule

// File: tb/tb_dadda_mult_pipe.sv
// tb_dadda_mult_pipe -- directed vector table on an 8-bit instance, stall,
// reset and random streaming sequences on 16-bit and 5-bit instances.
module tb_dadda_mult_pipe;

`ifdef DADDA_MULT_SIGNED_EN
  localparam bit SIGNED_ON = 1'b1;
`else
  localparam bit SIGNED_ON = 1'b0;
`endif
  localparam int NRAND = 10000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [7:0]  in_a, in_b;
  logic [15:0] out_p;
  bit          rand_go = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dadda_mult_pipe #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp_en;
    logic [15:0] exp_dis;
  } vec_t;

  vec_t vecs [13];

  // One isolated product: accept, count edges to out_valid, check value.
  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [15:0] exp, input string nm);
    int lat;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({nm, " in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, " latency"}, lat, 3);
    check({nm, " product"}, out_p, exp);
    @(posedge clk); #1;
  endtask

  // Random streaming on wider / narrower instances with a queue scoreboard
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rand
      localparam int W  = (gi == 0) ? 16 : 5;
      localparam int PW = 2 * W;
      logic          iv, ir, ov, orr, sg;
      logic [W-1:0]  ra, rb;
      logic [PW-1:0] op;
      bit            done = 1'b0;

      dadda_mult_pipe #(.WIDTH(W)) u_rdut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv),
        .in_ready  (ir),
        .in_a      (ra),
        .in_b      (rb),
        .in_signed (sg),
        .out_valid (ov),
        .out_ready (orr),
        .out_p     (op)
      );

      function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic s);
        longint xs, ys;
        if (s && SIGNED_ON) begin
          xs = longint'($signed(x));
          ys = longint'($signed(y));
        end else begin
          xs = longint'(x);
          ys = longint'(y);
        end
        return PW'(xs * ys);
      endfunction

      initial begin
        logic [PW-1:0] q [$];
        int sent, got, cyc;
        iv = 1'b0; ra = '0; rb = '0; sg = 1'b0; orr = 1'b0;
        sent = 0; got = 0; cyc = 0;
        wait (rand_go);
        @(posedge clk); #1;
        while (got < NRAND && cyc < 60000) begin
          iv  = (sent < NRAND) && ($urandom_range(0, 99) < 70);
          ra  = W'($urandom);
          rb  = W'($urandom);
          sg  = 1'($urandom_range(0, 1));
          orr = ($urandom_range(0, 99) < 70);
          #1;
          if (ov && orr) begin
            if (q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL w%0d extra product: got 0x%0h, expected none", W, op);
            end else begin
              check($sformatf("w%0d rand #%0d", W, got), op, q.pop_front());
            end
            got++;
          end
          if (iv && ir) begin
            q.push_back(ref_mul(ra, rb, sg));
            sent++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        iv  = 1'b0;
        orr = 1'b1;
        check($sformatf("w%0d rand count", W), got, NRAND);
        done = 1'b1;
      end
    end
  endgenerate

  initial begin
    int acc, got;
    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 16'hFE01};
    vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000, 16'h4000};
    vecs[2]  = '{8'hFF, 8'h02, 1'b1, 16'hFFFE, 16'h01FE};
    vecs[3]  = '{8'h80, 8'h80, 1'b0, 16'h4000, 16'h4000};
    vecs[4]  = '{8'hFF, 8'h02, 1'b0, 16'h01FE, 16'h01FE};
    vecs[5]  = '{8'h00, 8'h00, 1'b0, 16'h0000, 16'h0000};
    vecs[6]  = '{8'h0C, 8'h0D, 1'b0, 16'h009C, 16'h009C};
    vecs[7]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01, 16'h3F01};
    vecs[8]  = '{8'h7F, 8'h80, 1'b1, 16'hC080, 16'h3F80};
    vecs[9]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001, 16'hFE01};
    vecs[10] = '{8'hA5, 8'h3C, 1'b0, 16'h26AC, 16'h26AC};
    vecs[11] = '{8'h81, 8'hFE, 1'b1, 16'h00FE, 16'h7FFE};
    vecs[12] = '{8'h03, 8'h07, 1'b0, 16'h0015, 16'h0015};

    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset out_p", out_p, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("release in_ready", in_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      run_one(vecs[i].a, vecs[i].b, vecs[i].s,
              SIGNED_ON ? vecs[i].exp_en : vecs[i].exp_dis, $sformatf("vec%0d", i));
    end

    // Back-to-back squares with a 5-cycle output stall
    acc = 0;
    got = 0;
    for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid  = (acc < 10);
      in_a      = 8'(acc + 1);
      in_b      = 8'(acc + 1);
      in_signed = 1'b0;
      #1;
      if (cyc == 6) begin
        check("stall in_ready", in_ready, 0);
        check("stall in flight", acc - got, 3);
        check("stall hold valid", out_valid, 1);
        check("stall hold p", out_p, (got + 1) * (got + 1));
      end
      if (out_valid && out_ready) begin
        check($sformatf("stream out %0d", got), out_p, (got + 1) * (got + 1));
        got++;
      end
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stream count", got, 10);

    // Reset with two products in flight
    out_ready = 1'b0;
    in_valid  = 1'b1; in_a = 8'd5; in_b = 8'd5;
    @(posedge clk); #1;
    in_a = 8'd6; in_b = 8'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre-reset out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset out_p", out_p, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post-reset in_ready", in_ready, 1);
    got = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) got++;
      @(posedge clk); #1;
    end
    check("no stale product", got, 0);
    run_one(8'd3, 8'd7, 1'b0, 16'd21, "after reset 3*7");

    rand_go = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      if (g_rand[0].done && g_rand[1].done) break;
      @(posedge clk);
    end
    check("random streams finished", g_rand[0].done && g_rand[1].done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
